// File: rtl/reorder_buffer_pkg.sv
// Shared reorder-buffer sizing, instruction class codes and entry layout.
// Used by the buffer itself and by the decoder/LSB that exchange type codes with it.
package reorder_buffer_pkg;

    localparam int ROB_SIZE = 16;
    localparam int ROB_W    = 4;

    typedef enum logic [1:0] {
        ROB_ALU = 2'd0,
        ROB_BR  = 2'd1,
        ROB_ST  = 2'd2
    } rob_type_e;

    typedef struct packed {
        rob_type_e   typ;
        logic [4:0]  rd;
        logic [31:0] val;
        logic        pred_taken;
        logic        taken;
        logic [31:0] target;
    } rob_entry_t;

endpackage

// File: rtl/reorder_buffer.sv
// 16-entry in-order-retire reorder buffer: allocate on issue, capture CDB results, retire one per cycle.
// Commit is 2 cycles after the CDB write; issue is refused when full or around a flush; rdy low freezes all state.
module reorder_buffer
    import reorder_buffer_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             rdy,
    input  logic             issue_valid,
    input  logic [4:0]       issue_rd,
    input  logic [1:0]       issue_type,
    input  logic             issue_pred_taken,
    output logic             rob_full,
    output logic [ROB_W-1:0] issue_ROB_pos,
    input  logic             cdb_valid,
    input  logic [ROB_W-1:0] cdb_ROB_pos,
    input  logic [31:0]      cdb_val,
    input  logic             cdb_taken,
    input  logic [31:0]      cdb_target,
    input  logic [ROB_W-1:0] query1_pos,
    input  logic [ROB_W-1:0] query2_pos,
    output logic             query1_ready,
    output logic [31:0]      query1_val,
    output logic             query2_ready,
    output logic [31:0]      query2_val,
    output logic             update_valid,
    output logic [ROB_W-1:0] update_ROB_pos,
    output logic [4:0]       update_rd,
    output logic             commit_valid,
    output logic [ROB_W-1:0] commit_ROB_pos,
    output logic [4:0]       commit_rd,
    output logic [31:0]      commit_val,
    output logic             store_commit,
    output logic             jump_wrong,
    output logic [31:0]      jump_pc
);

    localparam logic [ROB_W:0] FULL_CNT = (ROB_W+1)'(ROB_SIZE);

    rob_entry_t          ent_q [ROB_SIZE];
    logic [ROB_SIZE-1:0] busy_q, ready_q;

    logic [ROB_W-1:0] head_q, head_d, tail_q, tail_d;
    logic [ROB_W:0]   count_q, count_d;
    logic             flush_pending_q, flush_pending_d;
    logic             jump_wrong_q, jump_wrong_d;
    logic [31:0]      jump_pc_q, jump_pc_d;
    logic             commit_valid_q, commit_valid_d;
    logic [ROB_W-1:0] commit_pos_q, commit_pos_d;
    logic [4:0]       commit_rd_q, commit_rd_d;
    logic [31:0]      commit_val_q, commit_val_d;
    logic             store_commit_q, store_commit_d;

    logic issue_acc, pop, cdb_wr, mispredict;
    logic cdb_hit1, cdb_hit2;

    // Both flush cycles block new work: the pending cycle and the jump_wrong cycle.
    assign issue_acc  = rdy && issue_valid && !rob_full && !flush_pending_q && !jump_wrong_q;
    assign pop        = busy_q[head_q] && ready_q[head_q] && !flush_pending_q && !jump_wrong_q;
    assign cdb_wr     = cdb_valid && busy_q[cdb_ROB_pos] && !jump_wrong_q;
    assign mispredict = (ent_q[head_q].typ == ROB_BR) &&
                        (ent_q[head_q].taken != ent_q[head_q].pred_taken);

    always_comb begin
        head_d          = head_q;
        tail_d          = tail_q;
        count_d         = count_q;
        flush_pending_d = flush_pending_q;
        jump_wrong_d    = 1'b0;
        jump_pc_d       = jump_pc_q;
        commit_valid_d  = 1'b0;
        commit_pos_d    = commit_pos_q;
        commit_rd_d     = commit_rd_q;
        commit_val_d    = commit_val_q;
        store_commit_d  = 1'b0;
        if (flush_pending_q) begin
            head_d          = '0;
            tail_d          = '0;
            count_d         = '0;
            flush_pending_d = 1'b0;
            jump_wrong_d    = 1'b1;
        end else begin
            if (issue_acc)
                tail_d = tail_q + 1'b1;
            if (pop) begin
                head_d         = head_q + 1'b1;
                commit_valid_d = 1'b1;
                commit_pos_d   = head_q;
                commit_rd_d    = ent_q[head_q].rd;
                commit_val_d   = ent_q[head_q].val;
                store_commit_d = (ent_q[head_q].typ == ROB_ST);
                if (mispredict) begin
                    flush_pending_d = 1'b1;
                    jump_pc_d       = ent_q[head_q].target;
                end
            end
            count_d = count_q + (ROB_W+1)'(issue_acc) - (ROB_W+1)'(pop);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q          <= '0;
            tail_q          <= '0;
            count_q         <= '0;
            flush_pending_q <= 1'b0;
            jump_wrong_q    <= 1'b0;
            jump_pc_q       <= '0;
            commit_valid_q  <= 1'b0;
            commit_pos_q    <= '0;
            commit_rd_q     <= '0;
            commit_val_q    <= '0;
            store_commit_q  <= 1'b0;
        end else if (rdy) begin
            head_q          <= head_d;
            tail_q          <= tail_d;
            count_q         <= count_d;
            flush_pending_q <= flush_pending_d;
            jump_wrong_q    <= jump_wrong_d;
            jump_pc_q       <= jump_pc_d;
            commit_valid_q  <= commit_valid_d;
            commit_pos_q    <= commit_pos_d;
            commit_rd_q     <= commit_rd_d;
            commit_val_q    <= commit_val_d;
            store_commit_q  <= store_commit_d;
        end
    end

    // Pop clears busy after the CDB write so a same-cycle broadcast to head cannot revive it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q  <= '0;
            ready_q <= '0;
            for (int i = 0; i < ROB_SIZE; i++)
                ent_q[i] <= '0;
        end else if (rdy) begin
            if (flush_pending_q) begin
                busy_q <= '0;
            end else begin
                if (cdb_wr) begin
                    ready_q[cdb_ROB_pos]       <= 1'b1;
                    ent_q[cdb_ROB_pos].val    <= cdb_val;
                    ent_q[cdb_ROB_pos].taken  <= cdb_taken;
                    ent_q[cdb_ROB_pos].target <= cdb_target;
                end
                if (issue_acc) begin
                    busy_q[tail_q]               <= 1'b1;
                    ready_q[tail_q]              <= 1'b0;
                    ent_q[tail_q].typ            <= rob_type_e'(issue_type);
                    ent_q[tail_q].rd             <= issue_rd;
                    ent_q[tail_q].pred_taken     <= issue_pred_taken;
                end
                if (pop)
                    busy_q[head_q] <= 1'b0;
            end
        end
    end

    assign cdb_hit1     = cdb_valid && (cdb_ROB_pos == query1_pos);
    assign cdb_hit2     = cdb_valid && (cdb_ROB_pos == query2_pos);
    assign query1_ready = ready_q[query1_pos] | cdb_hit1;
    assign query2_ready = ready_q[query2_pos] | cdb_hit2;
    assign query1_val   = cdb_hit1 ? cdb_val : ent_q[query1_pos].val;
    assign query2_val   = cdb_hit2 ? cdb_val : ent_q[query2_pos].val;

    assign rob_full       = (count_q == FULL_CNT);
    assign issue_ROB_pos  = tail_q;
    assign update_valid   = issue_acc;
    assign update_ROB_pos = tail_q;
    assign update_rd      = issue_rd;
    assign commit_valid   = commit_valid_q;
    assign commit_ROB_pos = commit_pos_q;
    assign commit_rd      = commit_rd_q;
    assign commit_val     = commit_val_q;
    assign store_commit   = store_commit_q;
    assign jump_wrong     = jump_wrong_q;
    assign jump_pc        = jump_pc_q;

endmodule
